// File: rtl/baseline_restorer.sv
// Per-channel ADC baseline restorer: gated EMA baseline tracker with pulse/holdoff freeze,
// baseline-subtracted saturated output with fixed two-cycle latency.
module baseline_restorer #(
    parameter int unsigned DW        = 14,
    parameter int unsigned MAX_SHIFT = 15
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 cfg_en_i,
    input  logic [3:0]           cfg_shift_i,
    input  logic [DW-2:0]        cfg_window_i,
    input  logic [15:0]          cfg_holdoff_i,
    output logic signed [DW-1:0] dat_o,
    output logic signed [DW-1:0] baseline_o,
    output logic [1:0]           state_o,
    output logic                 pulse_o
);

    localparam int unsigned AW = DW + MAX_SHIFT + 1;

    localparam logic [3:0]           MaxShift = 4'(MAX_SHIFT);
    localparam logic signed [DW-1:0] SatMax   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SatMin   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW:0]          DOne     = (DW+1)'(1);

    typedef enum logic [1:0] {
        StTrack = 2'b00,
        StPulse = 2'b01,
        StHold  = 2'b10
    } state_e;

    // S1 and tracker state
    logic signed [DW-1:0] r_x;
    logic                 r_vld;
    logic                 r_seed;
    logic [3:0]           r_shift;
    logic signed [AW-1:0] r_acc;
    logic [15:0]          r_cnt;
    state_e               r_state;

    // S2 output registers
    logic signed [DW-1:0] r_dat;
    logic signed [DW-1:0] r_base;
    logic                 r_pulse;

    logic [3:0]           w_shift_new;
    logic                 w_seed;
    logic signed [AW-1:0] w_x_ext;
    logic signed [AW-1:0] w_acc_sh;
    logic signed [AW-1:0] w_seed_acc;
    logic signed [AW-1:0] w_ema;
    logic signed [DW-1:0] w_base;
    logic [DW:0]          w_d;
    logic [DW:0]          w_mag;
    logic                 w_over;
    logic signed [DW-1:0] w_sat;

    logic signed [AW-1:0] w_acc_d;
    logic [15:0]          w_cnt_d;
    logic                 w_seed_d;
    state_e               w_state_d;

    always_comb begin
        w_shift_new = (cfg_shift_i > MaxShift) ? MaxShift : cfg_shift_i;
        // A shift change reseeds so the accumulator scale always matches the active shift.
        w_seed      = r_seed | (w_shift_new != r_shift);
        w_x_ext     = {{(AW-DW){r_x[DW-1]}}, r_x};
        w_acc_sh    = r_acc >>> r_shift;
        w_seed_acc  = w_x_ext <<< w_shift_new;
        w_ema       = r_acc + w_x_ext - w_acc_sh;
        w_base      = w_acc_sh[DW-1:0];
        w_d         = {r_x[DW-1], r_x} - {w_base[DW-1], w_base};
        w_mag       = w_d[DW] ? (~w_d + DOne) : w_d;
        w_over      = w_mag > {2'b00, cfg_window_i};
        if (w_d[DW] != w_d[DW-1]) begin
            w_sat = w_d[DW] ? SatMin : SatMax;
        end else begin
            w_sat = w_d[DW-1:0];
        end
    end

    always_comb begin
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        w_seed_d  = r_seed;
        w_state_d = r_state;
        if (r_vld) begin
            if (w_seed) begin
                w_acc_d   = w_seed_acc;
                w_state_d = StTrack;
                w_seed_d  = 1'b0;
            end else begin
                unique case (r_state)
                    StTrack: begin
                        if (w_over) begin
                            w_state_d = StPulse;
                        end else begin
                            w_acc_d = w_ema;
                        end
                    end
                    StPulse: begin
                        if (!w_over) begin
                            w_state_d = StHold;
                            w_cnt_d   = cfg_holdoff_i;
                        end
                    end
                    StHold: begin
                        if (w_over) begin
                            w_state_d = StPulse;
                        end else if (r_cnt == '0) begin
                            w_state_d = StTrack;
                        end else begin
                            w_cnt_d = r_cnt - 16'd1;
                        end
                    end
                    default: w_state_d = StTrack;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_x     <= '0;
            r_vld   <= 1'b0;
            r_seed  <= 1'b1;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= StTrack;
            r_dat   <= '0;
            r_base  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_x     <= dat_i;
            r_vld   <= 1'b1;
            r_seed  <= w_seed_d;
            r_shift <= w_shift_new;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
            r_state <= w_state_d;
            r_dat   <= cfg_en_i ? w_sat : r_x;
            r_base  <= w_base;
            r_pulse <= (w_state_d == StPulse);
        end
    end

    assign dat_o      = r_dat;
    assign baseline_o = r_base;
    assign state_o    = r_state;
    assign pulse_o    = r_pulse;

endmodule

// File: tb/tb_baseline_restorer.sv
// Directed bench for baseline_restorer: vector table for the pipeline/FSM walk,
// hand sequences for seeding, saturation, holdoff lengths, reset abort and EMA settling.
module tb_baseline_restorer;

    localparam int DW = 14;

    logic                 clk_i;
    logic                 rstn_i;
    logic signed [DW-1:0] dat_i;
    logic                 cfg_en_i;
    logic [3:0]           cfg_shift_i;
    logic [DW-2:0]        cfg_window_i;
    logic [15:0]          cfg_holdoff_i;
    logic signed [DW-1:0] dat_o;
    logic signed [DW-1:0] baseline_o;
    logic [1:0]           state_o;
    logic                 pulse_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int dat;
        int en;
        int e_dat;
        int e_base;
        int e_st;
        int e_p;
    } vec_t;

    vec_t tbl[21];

    baseline_restorer #(
        .DW        (DW),
        .MAX_SHIFT (15)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .dat_i         (dat_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_shift_i   (cfg_shift_i),
        .cfg_window_i  (cfg_window_i),
        .cfg_holdoff_i (cfg_holdoff_i),
        .dat_o         (dat_o),
        .baseline_o    (baseline_o),
        .state_o       (state_o),
        .pulse_o       (pulse_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_dat(input int v);
        dat_i = DW'(v);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        set_dat(0);
        cyc();
        cyc();
        rstn_i = 1'b1;
    endtask

    // Reset, then hold v until the seeded baseline is visible on baseline_o.
    task automatic seed_to(input int v);
        do_reset();
        set_dat(v);
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        int prev_base;
        int mono_viol, st_viol, sum_viol, base80;
        int pulse_cnt, hold_cnt, base_viol, dat_viol, run, last_run;

        rstn_i        = 1'b0;
        dat_i         = '0;
        cfg_en_i      = 1'b1;
        cfg_shift_i   = 4'd4;
        cfg_window_i  = 13'd50;
        cfg_holdoff_i = 16'd2;

        // dat, en -> dat_o, baseline_o, state_o, pulse_o seen after this row's edge
        tbl[0]  = '{500, 1, 0, 0, 0, 0};
        tbl[1]  = '{500, 1, 500, 0, 0, 0};
        tbl[2]  = '{500, 1, 0, 500, 0, 0};
        tbl[3]  = '{530, 1, 0, 500, 0, 0};
        tbl[4]  = '{600, 1, 30, 500, 0, 0};
        tbl[5]  = '{600, 1, 99, 501, 1, 1};
        tbl[6]  = '{500, 1, 99, 501, 1, 1};
        tbl[7]  = '{500, 1, -1, 501, 2, 0};
        tbl[8]  = '{500, 1, -1, 501, 2, 0};
        tbl[9]  = '{500, 1, -1, 501, 2, 0};
        tbl[10] = '{500, 0, 500, 501, 0, 0};
        tbl[11] = '{1234, 1, -1, 501, 0, 0};
        tbl[12] = '{500, 0, 1234, 501, 1, 1};
        tbl[13] = '{-100, 1, -1, 501, 2, 0};
        tbl[14] = '{500, 1, -601, 501, 1, 1};
        tbl[15] = '{500, 1, -1, 501, 2, 0};
        tbl[16] = '{500, 1, -1, 501, 2, 0};
        tbl[17] = '{500, 1, -1, 501, 2, 0};
        tbl[18] = '{500, 1, -1, 501, 0, 0};
        tbl[19] = '{500, 1, -1, 501, 0, 0};
        tbl[20] = '{500, 1, -1, 501, 0, 0};

        cyc();
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_base", int'(baseline_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_pulse", int'(pulse_o), 0);
        cyc();
        rstn_i = 1'b1;

        for (int i = 0; i < 21; i++) begin
            set_dat(tbl[i].dat);
            cfg_en_i = (tbl[i].en != 0);
            cyc();
            chk($sformatf("vec%0d_dat", i), int'(dat_o), tbl[i].e_dat);
            chk($sformatf("vec%0d_base", i), int'(baseline_o), tbl[i].e_base);
            chk($sformatf("vec%0d_state", i), int'(state_o), tbl[i].e_st);
            chk($sformatf("vec%0d_pulse", i), int'(pulse_o), tbl[i].e_p);
        end
        cfg_en_i = 1'b1;

        // Positive saturation, then reset aborts the pulse and the next sample reseeds.
        seed_to(-8000);
        chk("satp_seed_base", int'(baseline_o), -8000);
        set_dat(8191);
        cyc();
        cyc();
        chk("satp_dat", int'(dat_o), 8191);
        chk("satp_state", int'(state_o), 1);
        chk("satp_base", int'(baseline_o), -8000);
        rstn_i = 1'b0;
        set_dat(700);
        cyc();
        chk("abort_dat", int'(dat_o), 0);
        chk("abort_base", int'(baseline_o), 0);
        chk("abort_state", int'(state_o), 0);
        chk("abort_pulse", int'(pulse_o), 0);
        rstn_i = 1'b1;
        cyc();
        cyc();
        chk("reseed_dat", int'(dat_o), 700);
        chk("reseed_state", int'(state_o), 0);
        cyc();
        chk("reseed_base", int'(baseline_o), 700);
        chk("reseed_dat2", int'(dat_o), 0);

        // Negative saturation.
        seed_to(8000);
        set_dat(-8192);
        cyc();
        cyc();
        chk("satn_dat", int'(dat_o), -8192);
        chk("satn_state", int'(state_o), 1);

        // Shift change reseeds instead of rescaling the old accumulator.
        seed_to(700);
        cfg_shift_i = 4'd2;
        cyc();
        chk("shchg_seed_base", int'(baseline_o), 700);
        chk("shchg_seed_state", int'(state_o), 0);
        cyc();
        chk("shchg_base", int'(baseline_o), 700);
        chk("shchg_state", int'(state_o), 0);
        cfg_shift_i = 4'd4;
        cyc();
        cyc();
        chk("shchg_back_base", int'(baseline_o), 700);

        // Holdoff of zero gives exactly one HOLDOFF cycle.
        cfg_holdoff_i = 16'd0;
        set_dat(900);
        cyc();
        set_dat(700);
        cyc();
        chk("ho0_pulse_state", int'(state_o), 1);
        cyc();
        chk("ho0_hold_state", int'(state_o), 2);
        cyc();
        chk("ho0_track_state", int'(state_o), 0);

        // Window of zero: a one-LSB deviation is a pulse.
        cfg_window_i = 13'd0;
        set_dat(701);
        cyc();
        cyc();
        chk("win0_state", int'(state_o), 1);
        chk("win0_pulse", int'(pulse_o), 1);
        cfg_window_i = 13'd50;

        // EMA step response from a zero baseline.
        seed_to(0);
        set_dat(40);
        mono_viol = 0;
        st_viol   = 0;
        sum_viol  = 0;
        base80    = 0;
        prev_base = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (int'(baseline_o) < prev_base) mono_viol++;
            prev_base = int'(baseline_o);
            if (state_o != 2'b00) st_viol++;
            if (i >= 1 && int'(dat_o) + int'(baseline_o) != 40) sum_viol++;
            if (i == 81) base80 = int'(baseline_o);
        end
        chk("ema_monotonic_viol", mono_viol, 0);
        chk("ema_state_viol", st_viol, 0);
        chk("ema_dat_plus_base_viol", sum_viol, 0);
        chk("ema_base_ge39_after80", int'(base80 >= 39), 1);
        chk("ema_final_base", int'(baseline_o), 40);
        chk("ema_final_dat", int'(dat_o), 0);

        // 20-sample pulse with holdoff 10.
        cfg_holdoff_i = 16'd10;
        seed_to(100);
        pulse_cnt = 0;
        hold_cnt  = 0;
        base_viol = 0;
        dat_viol  = 0;
        for (int j = 0; j < 60; j++) begin
            set_dat((j < 20) ? 2000 : 100);
            cyc();
            if (pulse_o) pulse_cnt++;
            if (state_o == 2'b10) hold_cnt++;
            if (int'(baseline_o) != 100) base_viol++;
            if (pulse_o && int'(dat_o) != 1900) dat_viol++;
        end
        chk("p20_pulse_width", pulse_cnt, 20);
        chk("p20_hold_cycles", hold_cnt, 11);
        chk("p20_base_viol", base_viol, 0);
        chk("p20_dat_viol", dat_viol, 0);
        chk("p20_final_state", int'(state_o), 0);

        // Retrigger 5 cycles into HOLDOFF.
        seed_to(100);
        pulse_cnt = 0;
        hold_cnt  = 0;
        base_viol = 0;
        run       = 0;
        last_run  = 0;
        for (int j = 0; j < 70; j++) begin
            if (j < 20 || (j >= 25 && j < 28)) set_dat(2000);
            else set_dat(100);
            cyc();
            if (pulse_o) pulse_cnt++;
            if (int'(baseline_o) != 100) base_viol++;
            if (state_o == 2'b10) begin
                hold_cnt++;
                run++;
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
        end
        chk("rt_pulse_total", pulse_cnt, 23);
        chk("rt_hold_total", hold_cnt, 16);
        chk("rt_last_hold_run", last_run, 11);
        chk("rt_base_viol", base_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
